line_buffer_3x3_stride_pad: RTL and testbench
=============================================

# line_buffer_3x3_stride_pad

Parametrised 3x3 sliding-window line buffer for the convolution/pooling datapath, successor to the fixed stride-2 no-padding buffer. It takes a raster pixel stream and presents nine window taps, with stride selectable per frame and optional one-pixel zero padding. It inserts the padding internally, which stalls the source through `input_ready`. It sits between the frame source and the 3x3 MAC/pool array.

## Interface
- `data_width`, 16, pixel width in bits.
- `input_y`, 5, pixels per row W (>= 3).
- `input_x`, 5, rows per frame H (>= 3).
- `pad`, 0, 0 means no padding; 1 means a one-pixel zero border on all four sides.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sof` in 1: start-of-frame pulse, one cycle.
- `stride_2` in 1: 0 selects stride 1, 1 selects stride 2; sampled only in the `sof` cycle.
- `input_valid` in 1: `data_in` is valid.
- `input_ready` out 1: the block consumes `data_in` this cycle when `input_valid` is also high.
- `data_in` in `data_width`: raster pixel.
- `output_valid` out 1: taps hold a new window; high for one cycle per window.
- `frame_done` out 1: high with the last window of the frame.
- `data_out_0..data_out_8` out `data_width` each: window taps. 0..2 are the top row, 6..8 the bottom row; lower index is further left. `data_out_8` is the newest pixel.

## Operation
- Padded frame dimensions: Wp = W + 2·pad, Hp = H + 2·pad.
- Shift chain: 2·Wp + 3 registers of `data_width`.
  - `data_out_8/7/6` are at delays 0/1/2.
  - `data_out_5/4/3` are at delays Wp/Wp+1/Wp+2.
  - `data_out_2/1/0` are at delays 2Wp/2Wp+1/2Wp+2.
- A "push" shifts the chain by one. Position counters r (0..Hp-1) and c (0..Wp-1) track the pushed element; c wraps to 0 and r increments after Wp-1.
- A position is a pad position iff pad=1 and (r=0 or r=Hp-1 or c=0 or c=Wp-1).
  - At a pad position, zero is pushed unconditionally and `input_ready`=0.
  - At an interior position, `input_ready`=1 and a push of `data_in` occurs only when `input_valid`=1.
- FSM:
  - IDLE (after reset): `input_ready`=0, no pushes.
  - `sof` in any state: go to RUN. Clear r and c. Latch `stride_2` into a stride register s. Nothing is consumed in the `sof` cycle.
  - RUN: push per the rules above. The push at (Hp-1, Wp-1) moves to DONE.
  - DONE: `input_ready`=0. Wait for `sof`.
  - `sof` during RUN aborts the current frame and restarts. The chain is not cleared; stale data cannot reach a valid window because a window requires two fresh rows.
- Window emission: a push at (r, c) emits a window iff all of the following hold:
  - r >= 2 and c >= 2;
  - s=1, or both (r-2) and (c-2) are even.
- Windows per frame: ((Hp-3)/s+1)·((Wp-3)/s+1), using integer division.
- `frame_done` is asserted with the emitted window of the last row/column that satisfies the emission rule.
- Pixels arriving while `input_ready`=0 are ignored (not consumed).

## Timing
- Reset values: all chain registers and `data_out_*` = 0; `output_valid`, `frame_done`, `input_ready` = 0; FSM in IDLE; r, c, s = 0.
- `output_valid` is registered on the same edge as the completing push. It is high in the following cycle only. Taps hold their value until the next push.
- Latency from the completing push edge to `output_valid` is 0 cycles; valid and data appear together.
- `input_ready` is combinational from state and counters; it has no dependency on `input_valid`.
- With pad=1, a frame takes at least Hp·Wp cycles after the `sof` cycle, of which W·H consume input.
- `rst` overrides `sof`. `rst` mid-frame returns all state to its reset values.

## Test plan
- Case: pad=0, stride 1, W=H=5, ramp 1..25 with `input_valid` held high.
  - Expected: 9 windows. The first window follows pixel 13: out_0..8 = 1,2,3,6,7,8,11,12,13. `frame_done` is high with the ninth window.
- Case: pad=0, `stride_2`=1, same stimulus.
  - Expected: exactly 4 windows, after pixels 13, 15, 23, 25.
  - The second window is 3,4,5,8,9,10,13,14,15.
- Case: pad=1, stride 1, W=H=5, ramp 1..25.
  - Expected: `input_ready` is low for the first 8 RUN cycles. The first window is 0,0,0,0,1,2,0,6,7. There are 25 windows; the last is 19,20,0,24,25,0,0,0,0.
- Case: pad=1, stride 2.
  - Expected: 9 windows. `input_valid` is toggled randomly; the window contents match the stride-1 windows whose centres are at even coordinates.
- Case: `sof` issued after 12 pixels of a frame, then a full new ramp 101..125 is fed (pad=0).
  - Expected: no window contains a value below 101. There are 9 windows.
- Case: `rst` asserted mid-frame.
  - Expected: the next cycle shows all outputs at 0 and `input_ready`=0. No windows appear until the next `sof`.

Source files
------------

// File: rtl/line_buffer_3x3_stride_pad.sv
// 3x3 sliding-window line buffer with per-frame stride (1 or 2) and optional
// one-pixel zero border that is inserted internally while the source is stalled.
module line_buffer_3x3_stride_pad #(
  parameter int data_width = 16,
  parameter int input_y    = 5,
  parameter int input_x    = 5,
  parameter int pad        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic                  stride_2,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [data_width-1:0] data_in,
  output logic                  output_valid,
  output logic                  frame_done,
  output logic [data_width-1:0] data_out_0,
  output logic [data_width-1:0] data_out_1,
  output logic [data_width-1:0] data_out_2,
  output logic [data_width-1:0] data_out_3,
  output logic [data_width-1:0] data_out_4,
  output logic [data_width-1:0] data_out_5,
  output logic [data_width-1:0] data_out_6,
  output logic [data_width-1:0] data_out_7,
  output logic [data_width-1:0] data_out_8
);

  localparam int WP    = input_y + 2 * pad;
  localparam int HP    = input_x + 2 * pad;
  localparam int CHAIN = 2 * WP + 3;
  localparam int CW    = $clog2((HP > WP) ? HP : WP) + 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(WP - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(HP - 1);
  // Last emitting row/column when only even offsets from 2 produce windows.
  localparam logic [CW-1:0] COL_LAST2 = CW'(2 + 2 * ((WP - 3) / 2));
  localparam logic [CW-1:0] ROW_LAST2 = CW'(2 + 2 * ((HP - 3) / 2));
  localparam logic [CW-1:0] TWO       = CW'(2);
  localparam logic [CW-1:0] ZERO      = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CW-1:0]         row_r;
  logic [CW-1:0]         col_r;
  logic                  stride2_r;
  logic [data_width-1:0] chain_r [CHAIN];

  logic                  pad_pos_s;
  logic                  run_s;
  logic                  push_s;
  logic                  last_pos_s;
  logic                  emit_s;
  logic                  last_win_s;
  logic [data_width-1:0] push_data_s;

  // Handshake, push and window-emission decode from state and position counters.
  always_comb begin
    pad_pos_s   = (pad != 0) && ((row_r == ZERO) || (row_r == ROW_LAST) ||
                                 (col_r == ZERO) || (col_r == COL_LAST));
    run_s       = (state_r == ST_RUN) && !sof;
    input_ready = run_s && !pad_pos_s;
    push_s      = run_s && (pad_pos_s || input_valid);
    push_data_s = pad_pos_s ? {data_width{1'b0}} : data_in;
    last_pos_s  = (row_r == ROW_LAST) && (col_r == COL_LAST);
    // Stride 2 keeps only windows whose offsets from (2,2) are even.
    emit_s      = push_s && (row_r >= TWO) && (col_r >= TWO) &&
                  (!stride2_r || (!row_r[0] && !col_r[0]));
    last_win_s  = emit_s && (stride2_r ? ((row_r == ROW_LAST2) && (col_r == COL_LAST2))
                                       : last_pos_s);
  end

  // Frame sequencing: sof always (re)starts a frame, the final push ends it.
  always_comb begin
    state_nxt_s = state_r;
    if (sof) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_RUN:  state_nxt_s = (push_s && last_pos_s) ? ST_DONE : ST_RUN;
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, position counters, stride latch and window strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      row_r        <= ZERO;
      col_r        <= ZERO;
      stride2_r    <= 1'b0;
      output_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      output_valid <= emit_s;
      frame_done   <= last_win_s;
      if (sof) begin
        row_r     <= ZERO;
        col_r     <= ZERO;
        stride2_r <= stride_2;
      end else if (push_s) begin
        if (col_r == COL_LAST) begin
          col_r <= ZERO;
          row_r <= (row_r == ROW_LAST) ? ZERO : row_r + CW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
    end
  end

  // Pixel shift chain; index 0 holds the newest pushed element.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHAIN; i++) chain_r[i] <= {data_width{1'b0}};
    end else if (push_s) begin
      chain_r[0] <= push_data_s;
      for (int i = 1; i < CHAIN; i++) chain_r[i] <= chain_r[i-1];
    end
  end

  assign data_out_8 = chain_r[0];
  assign data_out_7 = chain_r[1];
  assign data_out_6 = chain_r[2];
  assign data_out_5 = chain_r[WP];
  assign data_out_4 = chain_r[WP+1];
  assign data_out_3 = chain_r[WP+2];
  assign data_out_2 = chain_r[2*WP];
  assign data_out_1 = chain_r[2*WP+1];
  assign data_out_0 = chain_r[2*WP+2];

endmodule

// File: tb/tb_line_buffer_3x3_stride_pad.sv
// Directed self-checking bench: one unpadded and one padded instance share the
// stimulus; sel picks which instance's outputs are observed.
module tb_line_buffer_3x3_stride_pad;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sof, stride_2, input_valid, sel;
  logic [DW-1:0] data_in;
  logic          v0, v1, fd0, fd1, r0, r1;
  logic [DW-1:0] t0 [9];
  logic [DW-1:0] t1 [9];

  logic            o_valid, o_fd, o_rdy;
  logic [9*DW-1:0] o_win;

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [9*DW-1:0] wins [$];
  logic [9*DW-1:0] expw [$];
  int              wcnt [$];
  bit              fdq  [$];
  logic [15:0]     rdy_trace;

  line_buffer_3x3_stride_pad #(.data_width(DW), .input_y(5), .input_x(5), .pad(0)) u0 (
    .clk(clk), .rst(rst), .sof(sof), .stride_2(stride_2), .input_valid(input_valid),
    .input_ready(r0), .data_in(data_in), .output_valid(v0), .frame_done(fd0),
    .data_out_0(t0[0]), .data_out_1(t0[1]), .data_out_2(t0[2]), .data_out_3(t0[3]),
    .data_out_4(t0[4]), .data_out_5(t0[5]), .data_out_6(t0[6]), .data_out_7(t0[7]),
    .data_out_8(t0[8]));

  line_buffer_3x3_stride_pad #(.data_width(DW), .input_y(5), .input_x(5), .pad(1)) u1 (
    .clk(clk), .rst(rst), .sof(sof), .stride_2(stride_2), .input_valid(input_valid),
    .input_ready(r1), .data_in(data_in), .output_valid(v1), .frame_done(fd1),
    .data_out_0(t1[0]), .data_out_1(t1[1]), .data_out_2(t1[2]), .data_out_3(t1[3]),
    .data_out_4(t1[4]), .data_out_5(t1[5]), .data_out_6(t1[6]), .data_out_7(t1[7]),
    .data_out_8(t1[8]));

  always_comb begin
    o_valid = sel ? v1 : v0;
    o_fd    = sel ? fd1 : fd0;
    o_rdy   = sel ? r1 : r0;
    o_win   = '0;
    for (int i = 0; i < 9; i++) o_win = {o_win[8*DW-1:0], (sel ? t1[i] : t0[i])};
  end

  task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {DW'(a0), DW'(a1), DW'(a2), DW'(a3), DW'(a4), DW'(a5), DW'(a6), DW'(a7), DW'(a8)};
  endfunction

  // Image in padded coordinates: zero border when padded, else base + raster index.
  function automatic logic [DW-1:0] pix(input int r, input int c, input bit pm, input int base);
    int hp;
    hp = 5 + 2 * int'(pm);
    if (pm && (r == 0 || c == 0 || r == hp - 1 || c == hp - 1)) return '0;
    return DW'(base + (r - int'(pm)) * 5 + (c - int'(pm)));
  endfunction

  function automatic logic [9*DW-1:0] mwin(input int r, input int c, input bit pm, input int base);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w = {w[8*DW-1:0], pix(r - 2 + i, c - 2 + j, pm, base)};
    return w;
  endfunction

  task automatic build_exp(input bit pm, input bit st, input int base);
    int hp;
    hp = 5 + 2 * int'(pm);
    expw.delete();
    for (int r = 2; r < hp; r++)
      for (int c = 2; c < hp; c++)
        if (!st || ((r % 2 == 0) && (c % 2 == 0))) expw.push_back(mwin(r, c, pm, base));
  endtask

  task automatic compare_all(input string tag);
    int nfd;
    nfd = 0;
    chk($sformatf("%s_count", tag), wins.size(), expw.size());
    for (int i = 0; i < wins.size() && i < expw.size(); i++)
      chk($sformatf("%s_win%0d", tag, i), wins[i], expw[i]);
    foreach (fdq[i]) if (fdq[i]) nfd++;
    chk($sformatf("%s_fd_count", tag), nfd, 1);
    chk($sformatf("%s_fd_last", tag), fdq[fdq.size()-1], 1'b1);
  endtask

  // Drives one frame (or the first npix pixels of one when partial) and logs windows.
  task automatic run_frame(input string tag, input bit ps, input bit st, input int base,
                           input int npix, input bit partial, input bit rnd);
    int cnt;
    bit take, done;
    cnt = 0;
    done = 1'b0;
    sel = ps;
    wins.delete(); wcnt.delete(); fdq.delete();
    rdy_trace = '0;
    sof = 1'b1; stride_2 = st; input_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sof = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      input_valid = (cnt < npix) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      data_in = DW'(base + cnt);
      #1;
      take = input_valid && o_rdy;
      if (cyc < 16) rdy_trace[cyc] = o_rdy;
      @(posedge clk);
      if (take) cnt++;
      @(negedge clk);
      if (o_valid) begin
        wins.push_back(o_win);
        wcnt.push_back(cnt);
        fdq.push_back(o_fd);
        if (o_fd) done = 1'b1;
      end
      if (partial && cnt == npix) done = 1'b1;
    end
    input_valid = 1'b0;
    chk($sformatf("%s_terminated", tag), done, 1'b1);
  endtask

  initial begin
    int nv, nr;
    bit ok;
    rst = 1'b1; sof = 1'b0; stride_2 = 1'b0; input_valid = 1'b0; data_in = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_fd", o_fd, 1'b0);
    chk("rst_ready", o_rdy, 1'b0);
    chk("rst_taps", o_win, '0);
    chk("rst_ready_pad", r1, 1'b0);
    rst = 1'b0;
    input_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", o_rdy, 1'b0);
    input_valid = 1'b0;

    // pad=0, stride 1
    run_frame("t1", 1'b0, 1'b0, 1, 25, 1'b0, 1'b0);
    build_exp(1'b0, 1'b0, 1);
    compare_all("t1");
    chk("t1_first", wins[0], w9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    chk("t1_first_after", wcnt[0], 13);
    chk("t1_last", wins[8], w9(13, 14, 15, 18, 19, 20, 23, 24, 25));

    // pad=0, stride 2
    run_frame("t2", 1'b0, 1'b1, 1, 25, 1'b0, 1'b0);
    build_exp(1'b0, 1'b1, 1);
    compare_all("t2");
    chk("t2_after0", wcnt[0], 13);
    chk("t2_after1", wcnt[1], 15);
    chk("t2_after2", wcnt[2], 23);
    chk("t2_after3", wcnt[3], 25);
    chk("t2_second", wins[1], w9(3, 4, 5, 8, 9, 10, 13, 14, 15));

    // pad=1, stride 1
    run_frame("t3", 1'b1, 1'b0, 1, 25, 1'b0, 1'b0);
    build_exp(1'b1, 1'b0, 1);
    compare_all("t3");
    chk("t3_ready_first8", rdy_trace[7:0], 8'h00);
    chk("t3_ready_ninth", rdy_trace[8], 1'b1);
    chk("t3_first", wins[0], w9(0, 0, 0, 0, 1, 2, 0, 6, 7));
    chk("t3_last", wins[24], w9(19, 20, 0, 24, 25, 0, 0, 0, 0));

    // pad=1, stride 2, random input_valid
    run_frame("t4", 1'b1, 1'b1, 1, 25, 1'b0, 1'b1);
    build_exp(1'b1, 1'b1, 1);
    compare_all("t4");

    // abort after 12 pixels, then full ramp 101..125
    run_frame("t5a", 1'b0, 1'b0, 1, 12, 1'b1, 1'b0);
    chk("t5_partial_windows", wins.size(), 0);
    run_frame("t5", 1'b0, 1'b0, 101, 25, 1'b0, 1'b0);
    ok = 1'b1;
    foreach (wins[i])
      for (int k = 0; k < 9; k++) if (wins[i][k*DW +: DW] < DW'(101)) ok = 1'b0;
    chk("t5_no_stale", ok, 1'b1);
    build_exp(1'b0, 1'b0, 101);
    compare_all("t5");

    // reset mid-frame
    run_frame("t6a", 1'b0, 1'b0, 1, 15, 1'b1, 1'b0);
    chk("t6_pre_taps_nonzero", (o_win != '0), 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_taps", o_win, '0);
    chk("t6_valid", o_valid, 1'b0);
    chk("t6_fd", o_fd, 1'b0);
    chk("t6_ready", o_rdy, 1'b0);
    rst = 1'b0;
    input_valid = 1'b1;
    nv = 0; nr = 0;
    for (int i = 0; i < 20; i++) begin
      data_in = DW'(200 + i);
      @(negedge clk);
      if (o_valid) nv++;
      if (o_rdy) nr++;
    end
    input_valid = 1'b0;
    chk("t6_no_windows", nv, 0);
    chk("t6_no_ready", nr, 0);
    run_frame("t6", 1'b0, 1'b0, 1, 25, 1'b0, 1'b0);
    build_exp(1'b0, 1'b0, 1);
    compare_all("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
